polyplay_dl_loader: RTL

Download sequencer between the HPS ioctl interface and the PolyPlay core. It routes ROM bytes (index 0) to the core's program-ROM write port and captures the title-number byte (index 1). It also holds the core in reset while any download is running and for a fixed settle time afterwards. It reports byte count, an 8-bit additive checksum and an out-of-range error for on-screen diagnostics.

---
 rtl/polyplay_dl_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/polyplay_dl_loader.sv
// polyplay_dl_loader: routes HPS ioctl downloads to the PolyPlay core.
// ROM bytes go to the program-ROM write port, and the title byte is captured.
// The core is held in reset during a download and for a settle time after it.
// Byte count, checksum and an out-of-range flag are kept for diagnostics.
module polyplay_dl_loader #(
    parameter int unsigned ROM_AW      = 16,
    parameter int unsigned ROM_INDEX   = 0,
    parameter int unsigned TITLE_INDEX = 1,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ROM_AW-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic [7:0]        tno,
    output logic              core_reset,
    output logic              dl_busy,
    output logic              dl_error,
    output logic [16:0]       byte_cnt,
    output logic [7:0]        checksum
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
    localparam logic [7:0] RomIdx = 8'(ROM_INDEX);
    localparam logic [7:0] TitleIdx = 8'(TITLE_INDEX);
    localparam logic [16:0] CntMax = 17'h1FFFF;

    typedef enum logic [1:0] {StIdle, StRomLoad, StTitleLoad, StHold} state_e;

    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ROM_AW-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]        dn_data_q, dn_data_d;
    logic              dn_wr_q, dn_wr_d;
    logic [7:0]        tno_q, tno_d;
    logic              core_reset_q, core_reset_d;
    logic              dl_busy_q, dl_busy_d;
    logic              dl_error_q, dl_error_d;
    logic [16:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]        checksum_q, checksum_d;

    logic start_rom, start_title, enter_rom, rom_wr, addr_ok;

    assign start_rom   = ioctl_download && (ioctl_index == RomIdx);
    assign start_title = ioctl_download && (ioctl_index == TitleIdx);
    assign addr_ok     = (ioctl_addr >> ROM_AW) == '0;

    // State and all registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_q      <= 1'b0;
            tno_q        <= '0;
            core_reset_q <= 1'b0;
            dl_busy_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            byte_cnt_q   <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_q      <= dn_wr_d;
            tno_q        <= tno_d;
            core_reset_q <= core_reset_d;
            dl_busy_q    <= dl_busy_d;
            dl_error_q   <= dl_error_d;
            byte_cnt_q   <= byte_cnt_d;
            checksum_q   <= checksum_d;
        end
    end

    // Next-state logic, including the post-download hold counter.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_rom) begin
                    state_d = StRomLoad;
                end else if (start_title) begin
                    state_d = StTitleLoad;
                end
            end
            StRomLoad, StTitleLoad: begin
                if (!ioctl_download) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                end
            end
            StHold: begin
                // A new download cuts the settle time short.
                if (start_rom) begin
                    state_d    = StRomLoad;
                    hold_cnt_d = '0;
                end else if (start_title) begin
                    state_d    = StTitleLoad;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next-values; writes only count inside a load state.
    always_comb begin
        enter_rom    = (state_d == StRomLoad) && (state_q != StRomLoad);
        rom_wr       = (state_q == StRomLoad) && ioctl_wr;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_wr_d      = 1'b0;
        tno_d        = tno_q;
        dl_error_d   = dl_error_q;
        byte_cnt_d   = byte_cnt_q;
        checksum_d   = checksum_q;
        core_reset_d = (state_d != StIdle);
        dl_busy_d    = (state_d == StRomLoad) || (state_d == StTitleLoad);

        if (enter_rom) begin
            dl_error_d = 1'b0;
            byte_cnt_d = '0;
            checksum_d = '0;
        end

        if (rom_wr) begin
            if (addr_ok) begin
                dn_addr_d  = ioctl_addr[ROM_AW-1:0];
                dn_data_d  = ioctl_dout;
                dn_wr_d    = 1'b1;
                checksum_d = checksum_q + ioctl_dout;
                if (byte_cnt_q != CntMax) begin
                    byte_cnt_d = byte_cnt_q + 17'd1;
                end
            end else begin
                dl_error_d = 1'b1;
            end
        end

        if ((state_q == StTitleLoad) && ioctl_wr && (ioctl_addr == '0)) begin
            tno_d = ioctl_dout;
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign tno        = tno_q;
    assign core_reset = core_reset_q;
    assign dl_busy    = dl_busy_q;
    assign dl_error   = dl_error_q;
    assign byte_cnt   = byte_cnt_q;
    assign checksum   = checksum_q;

endmodule
